// File: rtl/dm_access_m_if.sv
// Word-wide ready/valid data-memory port between the M-stage access controller and memory.
interface dm_access_m_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dm_access_m.sv
// M-stage load/store controller: decodes memops, drives the data-memory port,
// stalls F-M while a request is outstanding and returns the extended load value.
module dm_access_m #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RF_RD2_M,
    input  logic [31:0] PC_M,
    dm_access_m_if.master mem,
    output logic        stall_m,
    output logic [31:0] DMOut_M,
    output logic        addr_exc,
    output logic [31:0] exc_pc
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] cap_q;
    logic [5:0]  op;
    logic [1:0]  off;
    logic [31:0] addr_rel;
    logic        is_load, is_store, is_byte, is_half, is_signed;
    logic        misalign, mem_op;
    logic        req, stall, capture;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        unused_bits;

    assign op       = Instr_M[31:26];
    assign off      = AO_M[1:0];
    assign addr_rel = AO_M - MEM_BASE;
    assign unused_bits = ^{Instr_M[25:0], addr_rel[1:0]};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_LW:  is_load = 1'b1;
            OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
            OP_LH:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_SW:  is_store = 1'b1;
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            default: ;
        endcase
    end

    // Bytes never misalign; halves need an even offset; words need offset 0.
    assign misalign = is_byte ? 1'b0 : (is_half ? off[0] : (off != 2'b00));
    assign mem_op   = (is_load | is_store) & ~misalign;
    assign addr_exc = (is_load | is_store) & misalign;
    assign exc_pc   = addr_exc ? PC_M : 32'h0;

    assign mem.mem_addr = {addr_rel[31:2], 2'b00};
    assign mem.mem_we   = is_store;

    always_comb begin
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'h0;
        if (is_load) begin
            mem.mem_be = 4'b1111;
        end else if (is_store) begin
            if (is_byte) begin
                mem.mem_be    = 4'b0001 << off;
                mem.mem_wdata = {4{RF_RD2_M[7:0]}};
            end else if (is_half) begin
                mem.mem_be    = off[1] ? 4'b1100 : 4'b0011;
                mem.mem_wdata = {2{RF_RD2_M[15:0]}};
            end else begin
                mem.mem_be    = 4'b1111;
                mem.mem_wdata = RF_RD2_M;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (mem.mem_ready) begin
                        capture   = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem.mem_ready) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Reset withdraws the request in the same cycle, not just at the next edge.
        if (reset) begin
            req     = 1'b0;
            stall   = 1'b0;
            capture = 1'b0;
        end
    end

    assign mem.mem_req = req;
    assign stall_m     = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cap_q <= 32'h0;
        else if (capture && is_load) cap_q <= mem.mem_rdata;
    end

    always_comb begin
        case (off)
            2'd0:    sel_byte = cap_q[7:0];
            2'd1:    sel_byte = cap_q[15:8];
            2'd2:    sel_byte = cap_q[23:16];
            default: sel_byte = cap_q[31:24];
        endcase
        sel_half = off[1] ? cap_q[31:16] : cap_q[15:0];
    end

    // Inputs are still frozen on the same instruction in DONE, so decode is reused here.
    always_comb begin
        DMOut_M = 32'h0;
        if (state == ST_DONE && is_load) begin
            if (is_byte)
                DMOut_M = {{24{is_signed & sel_byte[7]}}, sel_byte};
            else if (is_half)
                DMOut_M = {{16{is_signed & sel_half[15]}}, sel_half};
            else
                DMOut_M = cap_q;
        end
    end
endmodule

// File: doc/dm_access_m.md
# dm_access_m

Memory-stage data-access controller for the five-stage MIPS pipeline. It consumes the M-stage register outputs (`Instr_M`, `AO_M`, `RF_RD2_M`, `PC_M`) and decodes load and store instructions. It drives a ready/valid word-wide data-memory port with byte enables and returns the aligned, extended load result to the M/W boundary. While a memory access is outstanding it asserts `stall_m`, which freezes stages F through M and inserts a bubble into W.

## Interface
Parameters:
- `MEM_BASE`, default 32'h0000_0000: base byte address subtracted from `AO_M` before `mem_addr` is formed.

Ports:
- `clk` in 1: pipeline clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `Instr_M` in 32: M-stage instruction.
- `AO_M` in 32: ALU result, the effective byte address.
- `RF_RD2_M` in 32: rt value, the store data.
- `PC_M` in 32: M-stage PC. Used only for `exc_pc`.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `(AO_M-MEM_BASE)` with `[1:0]` forced to 0.
- `mem_be` out 4: byte enables. Bit i corresponds to byte lane `[8i+7:8i]`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory accepts or completes the request this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready`=1 and `mem_we`=0.
- `stall_m` out 1: hold F–M, bubble W.
- `DMOut_M` out 32: extended load result.
- `addr_exc` out 1: misaligned access, asserted combinationally.
- `exc_pc` out 32: equals `PC_M` when `addr_exc`=1, else 0.

## Operation
- Decode uses opcode `Instr_M[31:26]`:
  - Loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - Stores: sw 101011, sb 101000, sh 101001.
  - Every other opcode is a non-memory instruction.
- Byte offset `off = AO_M[1:0]`. Byte order is little-endian.
- Misalignment rules:
  - Word ops require `off`=0.
  - Half ops require `off[0]`=0.
  - A misaligned op gives `addr_exc`=1, `mem_req`=0, `stall_m`=0, `DMOut_M`=0. The FSM stays in IDLE.
- Store lanes:
  - sw: be=1111, wdata=rt.
  - sh: be = `off[1]` ? 1100 : 0011, wdata={2{rt[15:0]}}.
  - sb: be = 0001<<off, wdata={4{rt[7:0]}}.
- Loads: be=1111, wdata=0.
- Load extraction from the captured word:
  - lb/lbu select the byte at `off`; lh/lhu select the half at `off[1]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, aligned memop: `mem_req`=1, `stall_m`=1. If `mem_ready`=1, capture `mem_rdata` and go to DONE; otherwise go to WAIT.
  - IDLE, non-memop: `mem_req`=0, `stall_m`=0, `DMOut_M`=0.
  - WAIT: `mem_req`=1 with address, enables and data held stable from `Instr_M`/`AO_M`/`RF_RD2_M` (frozen by the stall), `stall_m`=1. On `mem_ready`=1, capture and go to DONE.
  - DONE: `mem_req`=0, `stall_m`=0. `DMOut_M` comes from the capture register (stores give 0). Always return to IDLE next cycle.
- A request is never withdrawn once raised unless `reset` asserts.

## Timing
- Reset values, applied asynchronously: state=IDLE, capture register=0, `mem_req`=0, `stall_m`=0, `DMOut_M`=0.
  - With a memop present at reset release, `mem_req`/`stall_m` rise combinationally in the first IDLE cycle.
- Best case: memop in M at cycle 0 with `mem_ready`=1.
  - Cycle 0: stall.
  - Cycle 1: DONE, `DMOut_M` valid, pipeline advances at the end of cycle 1.
  - Total 2 cycles, 1 stall cycle.
- Each wait cycle adds one stall cycle.
- `mem_ready` is sampled only while `mem_req`=1. `mem_ready` pulses in IDLE with no memop, or in DONE, are ignored.
- Back-to-back memops: DONE→IDLE guarantees each instruction issues exactly one request.
- Reset during WAIT: `mem_req` drops in the same cycle, and the pending result is discarded.
- `addr_exc` and `exc_pc` are combinational from the current M-stage inputs.

## Test plan
- sw rt=32'hDEADBEEF, AO_M=32'h0000_0010, `mem_ready` tied 1 -> one cycle with `mem_req`=1, we=1, addr=32'h10, be=1111, wdata=DEADBEEF, `stall_m`=1. Next cycle `stall_m`=0.
- lb AO_M=32'h13, rdata=32'h80_12_34_56, `mem_ready` delayed 3 cycles -> `stall_m` high for 4 cycles, request stable throughout, then `DMOut_M`=32'hFFFF_FF80 for one DONE cycle.
- lhu AO_M=32'h22, rdata=32'h9ABC_1234 -> `DMOut_M`=32'h0000_9ABC. sh rt=32'h0000_5A5A at AO_M=32'h22 -> be=1100, wdata=32'h5A5A_5A5A.
- lw AO_M=32'h0000_0006, PC_M=32'h3010 -> `addr_exc`=1, `exc_pc`=32'h3010, `mem_req`=0, `stall_m`=0.
- Two consecutive lw instructions (addr 0 then 4), `mem_ready`=1 -> exactly two requests on separate cycles, pattern stall/DONE/stall/DONE.
- Reset pulsed mid-WAIT of a load -> `mem_req`, `stall_m` and `DMOut_M` go to 0 immediately. After release with the same lw present, the request re-issues from IDLE.
